alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequencer that drives the combinational N-bit ALU (`ALU_N_bits`) in the laboratory datapath. It collects two operands, one at a time, over a single valid/ready input bus and applies a latched 4-bit opcode. It captures the result and the V/C/N/Z flags in registers and presents them on a valid/ready output port. A chain mode reuses the previous result as operand A, so the ALU can run accumulate-style sequences without reloading.

## Interface

**Parameters**
- `N`, default 4, operand and result width.

**Ports**
- `tclk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  4  ALU control code; latched on accepted `start`.
- `chain`  in  1  latched on accepted `start`; reuse last result as A.
- `in_valid`  in  1  `in_data` holds an operand.
- `in_ready`  out  1  sequencer accepts an operand this cycle.
- `in_data`  in  N  operand bus, A first, then B.
- `alu_a`  out  N  to ALU `a`, driven from the A register.
- `alu_b`  out  N  to ALU `b`, driven from the B register.
- `alu_control`  out  4  to ALU `control`, driven from the op register.
- `alu_result`  in  N  from ALU `result`.
- `alu_v`, `alu_c`, `alu_n`, `alu_z`  in  1 each  ALU flags.
- `out_valid`  out  1  result registered and pending.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  N  registered result.
- `out_flags`  out  4  registered flags, ordered {v,c,n,z}.
- `busy`  out  1  state is not IDLE.
- `op_count`  out  8  number of completed operations, wraps modulo 256.

## Operation

**States:** IDLE, LOAD_A, LOAD_B, EXEC, DONE. All state is held in registers. Outputs are decoded from state and registers; there is no combinational input-to-output path except through the ALU.

- **IDLE**
  - `in_ready`=0, `busy`=0.
  - On `start`=1: latch `op` and `chain`.
  - If `chain`=1 and `acc_valid`=1: copy the accumulator into A and go to LOAD_B.
  - Otherwise go to LOAD_A. `chain`=1 with `acc_valid`=0 behaves as an ordinary load.
- **LOAD_A**
  - `in_ready`=1.
  - On `in_valid`: A <= `in_data`, go to LOAD_B.
  - With no `in_valid`, wait indefinitely.
- **LOAD_B**
  - `in_ready`=1.
  - On `in_valid`: B <= `in_data`, go to EXEC.
- **EXEC**
  - `in_ready`=0. The ALU settles for one full cycle.
  - At the closing edge: `out_data` <= `alu_result`, `out_flags` <= {`alu_v`,`alu_c`,`alu_n`,`alu_z`}, accumulator <= `alu_result`, `acc_valid` <= 1, `op_count` <= `op_count`+1. Go to DONE.
- **DONE**
  - `out_valid`=1. `out_data` and `out_flags` stay stable.
  - On `out_ready`: go to IDLE.
  - A `start` in the same cycle as `out_ready` is ignored; it is honoured only from IDLE.

**Other rules**
- `start` asserted outside IDLE is ignored and not queued.
- `op` and `chain` changes after acceptance have no effect until the next accepted `start`.
- `alu_a`, `alu_b` and `alu_control` always reflect the A, B and op registers, so they are stable throughout EXEC.
- Width: result and flags are taken verbatim from the ALU. No extension or truncation is done here.

## Timing

- **Reset values**
  - State IDLE.
  - A, B, op, accumulator, `out_data`, `out_flags` all = 0.
  - `acc_valid`=0, `op_count`=0, `out_valid`=0, `in_ready`=0, `busy`=0.
  - Outputs show these values immediately on `reset` assertion.
- **Reset mid-operation:** the pending operation is discarded, no result is produced, and `op_count` is not incremented.
- **Latency, normal operation, `in_valid` held high:**
  - `start` sampled at edge 0.
  - A captured at edge 1, B at edge 2.
  - Result captured at edge 3; `out_valid` is high from edge 3.
- **Latency, chained operation:** `out_valid` is high from edge 2.
- **Throughput:** minimum 5 cycles per normal operation and 4 per chained operation, including the DONE handshake cycle with `out_ready` held high.
- **`op_count` wrap:** 255 + 1 = 0.

## Test plan

The bench's ALU model returns a+b (mod 2^N) with correct flags for op 4'h0, and a−b for op 4'h1. N=4.

1. **Reset.** Assert `reset` during LOAD_B. Required: all outputs at their reset values; after release, state IDLE and `op_count`=0.
2. **Basic add.** `start`, op=0, A=3, B=4, `in_valid` high, `out_ready` high. Required: `out_valid` at edge 3, `out_data`=7, `out_flags`=4'b0000, `op_count`=1.
3. **Overflow.** op=0, A=7, B=1. Required: `out_data`=8, flags v=1, n=1, c=0, z=0.
4. **Chain.**
   - op=0, A=5, B=2 gives 7.
   - Then `start` with `chain`=1, op=1, B=7. Required: `in_ready` skips LOAD_A, `out_data`=0, z=1, `out_valid` at edge 2.
5. **Backpressure and ignored start.**
   - Hold `out_ready`=0 for 6 cycles while pulsing `start`. Required: `out_data` and `out_flags` stable, no new operation begins.
   - `in_valid` gaps in LOAD_A and LOAD_B stall with `in_ready`=1.
6. **Counter wrap.** Run 256 operations. Required: `op_count` returns to 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Operand input and result output handshake bundle for alu_op_sequencer.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface alu_op_sequencer_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [3:0]   out_flags;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer around a combinational N-bit ALU: loads operands A then B over a
// valid/ready bus (or reuses the last result as A in chain mode), lets the ALU
// settle for one cycle, and holds the registered result and {v,c,n,z} flags
// on a valid/ready output until the consumer takes them.
module alu_op_sequencer #(
    parameter int N = 4
) (
    input  logic                 tclk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic                 chain,
    alu_op_sequencer_if.master   bus,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [3:0]           alu_control,
    input  logic [N-1:0]         alu_result,
    input  logic                 alu_v,
    input  logic                 alu_c,
    input  logic                 alu_n,
    input  logic                 alu_z,
    output logic                 busy,
    output logic [7:0]           op_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic         accept_start;
    logic         use_acc;
    logic         load_a;
    logic         load_b;
    logic         capture;

    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [3:0]   op_q;
    logic [N-1:0] acc_q;
    logic         acc_valid_q;
    logic [N-1:0] out_data_q;
    logic [3:0]   out_flags_q;
    logic [7:0]   op_count_q;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the load/capture strobes for the datapath registers.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        use_acc      = 1'b0;
        load_a       = 1'b0;
        load_b       = 1'b0;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    // Chain without a previous result falls back to a normal load.
                    if (chain && acc_valid_q) begin
                        use_acc = 1'b1;
                        state_d = LOAD_B;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                if (bus.in_valid) begin
                    load_a  = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (bus.in_valid) begin
                    load_b  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // A start arriving with out_ready is dropped; only IDLE accepts it.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand and opcode registers feeding the ALU; stable from load through DONE.
    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            if (accept_start) begin
                op_q <= op;
            end
            if (use_acc) begin
                a_q <= acc_q;
            end else if (load_a) begin
                a_q <= bus.in_data;
            end
            if (load_b) begin
                b_q <= bus.in_data;
            end
        end
    end

    // Result, flags, accumulator and completion counter captured at the end of EXEC.
    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_flags_q <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else if (capture) begin
            out_data_q  <= alu_result;
            out_flags_q <= {alu_v, alu_c, alu_n, alu_z};
            acc_q       <= alu_result;
            acc_valid_q <= 1'b1;
            op_count_q  <= op_count_q + 8'd1;
        end
    end

    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_control   = op_q;

    assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    assign busy          = (state_q != IDLE);
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with N=4: a behavioural ALU (add for op 0,
// subtract for op 1), a table of directed operations with hand-computed
// results, and hand-written reset, backpressure, stall and wrap sequences.
module tb_alu_op_sequencer;

    localparam int N = 4;

    logic         tclk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic         chain;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_v;
    logic         alu_c;
    logic         alu_n;
    logic         alu_z;
    logic         busy;
    logic [7:0]   op_count;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   exp_cnt = 8'd0;

    alu_op_sequencer_if #(.N(N)) bus ();

    alu_op_sequencer #(.N(N)) dut (
        .tclk        (tclk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .chain       (chain),
        .bus         (bus.master),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .busy        (busy),
        .op_count    (op_count)
    );

    always #5 tclk = ~tclk;

    // Reference ALU: returns {v,c,n,z,result[3:0]}; c is carry-out (no borrow on subtract).
    function automatic logic [7:0] alu_ref(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic       v;
        case (o)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[3] == b[3]) && (s[3] != a[3]);
            end
            4'h1: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                v = (a[3] != b[3]) && (s[3] != a[3]);
            end
            default: begin
                s = 5'd0;
                v = 1'b0;
            end
        endcase
        return {v, s[4], s[3], (s[3:0] == 4'd0), s[3:0]};
    endfunction

    assign {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_ref(alu_control, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic       chain;
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
        logic [3:0] data;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[8];

    // One full operation with out_ready high; checks latency, result, flags and count.
    task automatic run_op(input logic [3:0] o, input logic ch, input logic [3:0] a, input logic [3:0] b,
                          input int lat, input logic [3:0] ed, input logic [3:0] ef, input string name);
        int edges;
        bit seen;
        edges = 0;
        seen  = 1'b0;
        @(negedge tclk);
        start         = 1'b1;
        op            = o;
        chain         = ch;
        bus.in_valid  = 1'b1;
        bus.in_data   = (lat == 2) ? b : a;
        bus.out_ready = 1'b1;
        @(posedge tclk);
        @(negedge tclk);
        start = 1'b0;
        op    = 4'hF;
        chain = 1'b0;
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_in_ready"}, bus.in_ready, 1'b1);
        while (!seen && edges < 10) begin
            @(posedge tclk);
            edges++;
            @(negedge tclk);
            if (edges == 1) bus.in_data = b;
            if (bus.out_valid) seen = 1'b1;
        end
        bus.in_valid = 1'b0;
        exp_cnt      = exp_cnt + 8'd1;
        check({name, "_latency"}, edges, lat);
        check({name, "_data"}, bus.out_data, ed);
        check({name, "_flags"}, bus.out_flags, ef);
        check({name, "_op_count"}, op_count, exp_cnt);
        @(posedge tclk);
        @(negedge tclk);
        check({name, "_idle"}, {busy, bus.out_valid}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{op: 4'h0, chain: 1'b1, a: 4'd2, b: 4'd3,  lat: 3, data: 4'd5,  flags: 4'b0000};
        vecs[1] = '{op: 4'h0, chain: 1'b0, a: 4'd3, b: 4'd4,  lat: 3, data: 4'd7,  flags: 4'b0000};
        vecs[2] = '{op: 4'h0, chain: 1'b0, a: 4'd7, b: 4'd1,  lat: 3, data: 4'd8,  flags: 4'b1010};
        vecs[3] = '{op: 4'h0, chain: 1'b0, a: 4'd5, b: 4'd2,  lat: 3, data: 4'd7,  flags: 4'b0000};
        vecs[4] = '{op: 4'h1, chain: 1'b1, a: 4'hA, b: 4'd7,  lat: 2, data: 4'd0,  flags: 4'b0101};
        vecs[5] = '{op: 4'h0, chain: 1'b1, a: 4'hA, b: 4'd9,  lat: 2, data: 4'd9,  flags: 4'b0010};
        vecs[6] = '{op: 4'h1, chain: 1'b0, a: 4'd3, b: 4'd5,  lat: 3, data: 4'd14, flags: 4'b0010};
        vecs[7] = '{op: 4'h1, chain: 1'b1, a: 4'hA, b: 4'd15, lat: 2, data: 4'd15, flags: 4'b0010};

        reset         = 1'b1;
        start         = 1'b0;
        op            = 4'h0;
        chain         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge tclk);
        @(negedge tclk);
        reset = 1'b0;

        // Reset asserted in LOAD_B discards the operation.
        @(negedge tclk);
        start         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'd6;
        bus.out_ready = 1'b1;
        @(posedge tclk);
        @(negedge tclk);
        start = 1'b0;
        @(posedge tclk);
        @(negedge tclk);
        bus.in_valid = 1'b0;
        check("rst_pre_in_ready", bus.in_ready, 1'b1);
        check("rst_pre_alu_a", alu_a, 4'd6);
        #2 reset = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 4'd0);
        check("rst_out_flags", bus.out_flags, 4'd0);
        check("rst_op_count", op_count, 8'd0);
        check("rst_alu_regs", {alu_a, alu_b, alu_control}, 12'd0);
        @(negedge tclk);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge tclk);
        bus.in_valid = 1'b0;
        check("rst_after_busy", busy, 1'b0);
        check("rst_after_out_valid", bus.out_valid, 1'b0);
        check("rst_after_op_count", op_count, 8'd0);

        // Directed vectors, including chain with no accumulator yet (vector 0).
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].chain, vecs[i].a, vecs[i].b, vecs[i].lat,
                   vecs[i].data, vecs[i].flags, $sformatf("vec%0d", i));
        end

        // Input stalls in LOAD_A/LOAD_B, then held result under backpressure.
        @(negedge tclk);
        bus.out_ready = 1'b0;
        start         = 1'b1;
        op            = 4'h0;
        chain         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'hF;
        @(posedge tclk);
        @(negedge tclk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_a_in_ready", {bus.in_ready, busy}, 2'b11);
            @(negedge tclk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd9;
        @(negedge tclk);
        bus.in_valid = 1'b0;
        bus.in_data  = 4'hF;
        for (int k = 0; k < 2; k++) begin
            check("stall_b_in_ready", {bus.in_ready, bus.out_valid}, 2'b10);
            @(negedge tclk);
        end
        check("stall_b_alu_a", alu_a, 4'd9);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd6;
        @(negedge tclk);
        bus.in_valid = 1'b0;
        @(negedge tclk);
        exp_cnt = exp_cnt + 8'd1;
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_data", bus.out_data, 4'd15);
        check("bp_flags", bus.out_flags, 4'b0010);
        for (int k = 0; k < 6; k++) begin
            start = k[0];
            op    = 4'h1;
            chain = k[1];
            @(negedge tclk);
            check("bp_hold_data", {bus.out_valid, bus.out_flags, bus.out_data}, {1'b1, 4'b0010, 4'd15});
            check("bp_hold_count", op_count, exp_cnt);
        end
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge tclk);
        start = 1'b0;
        check("bp_start_ignored", busy, 1'b0);
        @(negedge tclk);
        @(negedge tclk);
        check("bp_not_queued", {busy, bus.in_ready}, 2'b00);

        // Run until the completion counter wraps back to zero.
        begin
            int j;
            logic [7:0] r;
            logic [3:0] av;
            logic [3:0] bv;
            j = 0;
            do begin
                av = j[3:0];
                bv = 4'd3;
                r  = alu_ref(4'h0, av, bv);
                run_op(4'h0, 1'b0, av, bv, 3, r[3:0], r[7:4], "wrap");
                j++;
            end while (exp_cnt != 8'd0 && j < 300);
        end
        check("wrap_op_count", op_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
